// File: rtl/xup_toggle_detect_vector_pkg.sv
// rtl/xup_toggle_detect_vector_pkg.sv - shared types for the toggle-detect vector block
package xup_toggle_detect_vector_pkg;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/xup_sync_vector.sv
// rtl/xup_sync_vector.sv - 2-flop synchronizer for a vector, async active-low clear
module xup_sync_vector #(
  parameter int unsigned SIZE = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] s
);

  logic [SIZE-1:0] meta_d, meta_q;
  logic [SIZE-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign s = sync_q;

endmodule

// File: rtl/xup_toggle_detect_vector.sv
// rtl/xup_toggle_detect_vector.sv - recovers per-bit toggles of a TFF-driven vector
module xup_toggle_detect_vector
  import xup_toggle_detect_vector_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned SYNC  = 1,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DELAY = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SIZE-1:0]  d,
  input  logic             en,
  input  logic             ack,
  output logic [SIZE-1:0]  t,
  output logic [SIZE-1:0]  q,
  output logic [SIZE-1:0]  pending,
  output logic             valid,
  output logic             ovf,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Registered outputs update with zero delay here; DELAY only matters to sim-only models.
  logic unused_delay;
  assign unused_delay = (DELAY != 0);

  logic [SIZE-1:0] s;

  generate
    if (SYNC != 0) begin : g_sync
      xup_sync_vector #(.SIZE(SIZE)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d),
        .s       (s)
      );
    end else begin : g_nosync
      assign s = d;
    end
  endgenerate

  state_e           state_d, state_q;
  logic [SIZE-1:0]  t_d, t_q;
  logic [SIZE-1:0]  q_d, q_q;
  logic [SIZE-1:0]  pending_d, pending_q;
  logic             ovf_d, ovf_q;
  logic [CNT_W-1:0] evt_cnt_d, evt_cnt_q;
  logic [SIZE-1:0]  tn;
  logic             sample_run;
  logic [CNT_W-1:0] evt_base;

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    q_d        = q_q;
    tn         = s ^ q_q;
    sample_run = en && (state_q == ST_RUN);

    case (state_q)
      ST_PRIME: begin
        // First sample only seeds q so reset-to-live transitions are not reported.
        if (en) begin
          q_d     = s;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (en) begin
          t_d = tn;
          q_d = s;
        end
      end
      default: state_d = ST_PRIME;
    endcase

    pending_d = (ack ? '0 : pending_q) | (sample_run ? tn : '0);
    ovf_d     = ack ? 1'b0 : (ovf_q | (sample_run && |(tn & pending_q)));

    evt_base = ack ? '0 : evt_cnt_q;
    if (sample_run && (tn != '0) && (evt_base != CNT_MAX)) begin
      evt_cnt_d = evt_base + CNT_W'(1);
    end else begin
      evt_cnt_d = evt_base;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_PRIME;
      t_q       <= '0;
      q_q       <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      q_q       <= q_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign t       = t_q;
  assign q       = q_q;
  assign pending = pending_q;
  assign valid   = |pending_q;
  assign ovf     = ovf_q;
  assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_xup_toggle_detect_vector.sv
// tb/tb_xup_toggle_detect_vector.sv - scoreboard bench for xup_toggle_detect_vector
module tb_xup_toggle_detect_vector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DUT A: SYNC=0, CNT_W=8
  logic       rst_a = 1'b0;
  logic [3:0] d_a = '0;
  logic       en_a = 1'b0, ack_a = 1'b0;
  logic [3:0] t_a, q_a, p_a;
  logic       v_a, o_a;
  logic [7:0] c_a;

  xup_toggle_detect_vector #(.SIZE(4), .SYNC(0), .CNT_W(8)) u_a (
    .clk(clk), .reset_n(rst_a), .d(d_a), .en(en_a), .ack(ack_a),
    .t(t_a), .q(q_a), .pending(p_a), .valid(v_a), .ovf(o_a), .evt_cnt(c_a)
  );

  // DUT B: SYNC=0, CNT_W=2
  logic       rst_b = 1'b0;
  logic [3:0] d_b = '0;
  logic       en_b = 1'b0, ack_b = 1'b0;
  logic [3:0] t_b, q_b, p_b;
  logic       v_b, o_b;
  logic [1:0] c_b;

  xup_toggle_detect_vector #(.SIZE(4), .SYNC(0), .CNT_W(2)) u_b (
    .clk(clk), .reset_n(rst_b), .d(d_b), .en(en_b), .ack(ack_b),
    .t(t_b), .q(q_b), .pending(p_b), .valid(v_b), .ovf(o_b), .evt_cnt(c_b)
  );

  // DUT C: SYNC=1, fed by a TFF vector sharing its enable
  logic       rst_c = 1'b0;
  logic [3:0] tff_q;
  logic [3:0] tff_t = '0;
  logic       tff_en = 1'b0;
  logic       ack_c = 1'b0;
  logic [3:0] t_c, q_c, p_c;
  logic       v_c, o_c;
  logic [7:0] c_c;

  always @(posedge clk or negedge rst_c) begin
    if (!rst_c) tff_q <= '0;
    else if (tff_en) tff_q <= tff_q ^ tff_t;
  end

  xup_toggle_detect_vector #(.SIZE(4), .SYNC(1), .CNT_W(8)) u_c (
    .clk(clk), .reset_n(rst_c), .d(tff_q), .en(tff_en), .ack(ack_c),
    .t(t_c), .q(q_c), .pending(p_c), .valid(v_c), .ovf(o_c), .evt_cnt(c_c)
  );

  typedef struct {
    string      nm;
    int         cyc;
    logic [3:0] t, q, p;
    logic       v, o;
    logic [7:0] c;
    bit         all;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  task automatic push(input int which, input string nm, input logic [3:0] t, input logic [3:0] q,
                      input logic [3:0] p, input logic v, input logic o, input logic [7:0] c,
                      input bit all);
    exp_t e;
    e.nm = nm; e.cyc = cyc; e.t = t; e.q = q; e.p = p; e.v = v; e.o = o; e.c = c; e.all = all;
    case (which)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic cmp(input exp_t e, input logic [3:0] t, input logic [3:0] q, input logic [3:0] p,
                     input logic v, input logic o, input logic [7:0] c);
    bit bad;
    checks++;
    if (e.all) bad = (t !== e.t) || (q !== e.q) || (p !== e.p) || (v !== e.v) || (o !== e.o) || (c !== e.c);
    else       bad = (t !== e.t) || (q !== e.q);
    if (bad) begin
      errors++;
      $display("FAIL %s cyc=%0d: got t=%b q=%b pend=%b valid=%b ovf=%b cnt=%0d, expected t=%b q=%b pend=%b valid=%b ovf=%b cnt=%0d",
               e.nm, e.cyc, t, q, p, v, o, c, e.t, e.q, e.p, e.v, e.o, e.c);
    end
  endtask

  task automatic stale(input exp_t e);
    checks++;
    errors++;
    $display("FAIL %s: expectation for cyc=%0d never observed (now cyc=%0d)", e.nm, e.cyc, cyc);
  endtask

  // Monitor: compares every expectation scheduled for the current cycle, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (qa.size() > 0 && qa[0].cyc <= cyc) begin
        e = qa.pop_front();
        if (e.cyc < cyc) stale(e); else cmp(e, t_a, q_a, p_a, v_a, o_a, c_a);
      end
      while (qb.size() > 0 && qb[0].cyc <= cyc) begin
        e = qb.pop_front();
        if (e.cyc < cyc) stale(e); else cmp(e, t_b, q_b, p_b, v_b, o_b, {6'b0, c_b});
      end
      while (qc.size() > 0 && qc[0].cyc <= cyc) begin
        e = qc.pop_front();
        if (e.cyc < cyc) stale(e); else cmp(e, t_c, q_c, p_c, v_c, o_c, c_c);
      end
    end
  end

  task automatic step_a(input logic [3:0] d, input logic en, input logic ack);
    d_a = d; en_a = en; ack_a = ack;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic [3:0] d, input logic en, input logic ack);
    d_b = d; en_b = en; ack_b = ack;
    @(posedge clk); #1;
  endtask

  logic [3:0] qh [0:1023];
  logic [3:0] exp_q_c, exp_t_c;
  bit         primed;
  int         last_m;
  logic       en_now;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1);
  end

  initial begin
    // ---- A: reset, PRIME swallow, toggles, hold, ovf, ack, set-wins ----
    repeat (2) @(posedge clk);
    #1;
    push(0, "a_reset", 4'b0000, 4'b0000, 4'b0000, 0, 0, 8'd0, 1);
    rst_a = 1'b1;
    step_a(4'b1010, 1, 0); push(0, "a_prime",    4'b0000, 4'b1010, 4'b0000, 0, 0, 8'd0, 1);
    step_a(4'b1000, 1, 0); push(0, "a_toggle",   4'b0010, 4'b1000, 4'b0010, 1, 0, 8'd1, 1);
    for (int i = 0; i < 5; i++) begin
      step_a(4'b1111, 0, 0); push(0, "a_hold",   4'b0010, 4'b1000, 4'b0010, 1, 0, 8'd1, 1);
    end
    step_a(4'b1010, 1, 0); push(0, "a_ovf",      4'b0010, 4'b1010, 4'b0010, 1, 1, 8'd2, 1);
    step_a(4'b1010, 0, 1); push(0, "a_ack",      4'b0010, 4'b1010, 4'b0000, 0, 0, 8'd0, 1);
    step_a(4'b1110, 1, 1); push(0, "a_ack_en",   4'b0100, 4'b1110, 4'b0100, 1, 0, 8'd1, 1);
    step_a(4'b1010, 1, 1); push(0, "a_set_wins", 4'b0100, 4'b1010, 4'b0100, 1, 0, 8'd1, 1);
    step_a(4'b1011, 1, 0); push(0, "a_accum",    4'b0001, 4'b1011, 4'b0101, 1, 0, 8'd2, 1);
    step_a(4'b1011, 1, 0); push(0, "a_zero_t",   4'b0000, 4'b1011, 4'b0101, 1, 0, 8'd2, 1);
    step_a(4'b1011, 0, 1); push(0, "a_ack2",     4'b0000, 4'b1011, 4'b0000, 0, 0, 8'd0, 1);
    step_a(4'b1011, 0, 1); push(0, "a_ack_idle", 4'b0000, 4'b1011, 4'b0000, 0, 0, 8'd0, 1);
    step_a(4'b1011, 0, 0);

    // ---- B: CNT_W=2 saturation, async reset mid-burst, re-prime ----
    rst_b = 1'b1;
    step_b(4'b0000, 1, 0); push(1, "b_prime", 4'b0000, 4'b0000, 4'b0000, 0, 0, 8'd0, 1);
    step_b(4'b0001, 1, 0); push(1, "b_cnt1",  4'b0001, 4'b0001, 4'b0001, 1, 0, 8'd1, 1);
    step_b(4'b0000, 1, 0); push(1, "b_cnt2",  4'b0001, 4'b0000, 4'b0001, 1, 1, 8'd2, 1);
    step_b(4'b0001, 1, 0); push(1, "b_cnt3",  4'b0001, 4'b0001, 4'b0001, 1, 1, 8'd3, 1);
    step_b(4'b0000, 1, 0); push(1, "b_sat4",  4'b0001, 4'b0000, 4'b0001, 1, 1, 8'd3, 1);
    step_b(4'b0001, 1, 0); push(1, "b_sat5",  4'b0001, 4'b0001, 4'b0001, 1, 1, 8'd3, 1);
    d_b = 4'b0000;
    @(posedge clk); #2;
    rst_b = 1'b0;
    push(1, "b_async_reset", 4'b0000, 4'b0000, 4'b0000, 0, 0, 8'd0, 1);
    @(negedge clk); #1;
    rst_b = 1'b1; d_b = 4'b0110; en_b = 1'b1;
    @(posedge clk); #1;
    push(1, "b_reprime", 4'b0000, 4'b0110, 4'b0000, 0, 0, 8'd0, 1);
    step_b(4'b0111, 1, 0); push(1, "b_after", 4'b0001, 4'b0111, 4'b0001, 1, 0, 8'd1, 1);
    en_b = 1'b0;

    // ---- C: SYNC=1 against a live TFF vector with random toggles/enables ----
    for (int i = 0; i < 1024; i++) qh[i] = 4'b0000;
    rst_c  = 1'b1;
    primed = 1'b0;
    last_m = 0;
    for (int n = 0; n < 1000; n++) begin
      tff_t  = 4'($urandom);
      tff_en = ($urandom_range(0, 3) != 0);
      en_now = tff_en;
      @(posedge clk); #1;
      qh[n + 3] = tff_q;
      if (en_now) begin
        exp_q_c = qh[n];
        exp_t_c = primed ? (qh[n] ^ qh[last_m]) : 4'b0000;
        push(2, "c_tff", exp_t_c, exp_q_c, 4'b0000, 0, 0, 8'd0, 0);
        primed = 1'b1;
        last_m = n;
      end
    end
    tff_en = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expectations left unchecked, expected 0", qa.size() + qb.size() + qc.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
